alu_arbiter_ctrl: RTL and testbench
===================================

// Module: alu_arbiter_ctrl
// PURPOSE
//   Shares one 16-bit ALU datapath between two requesters. Runs round-robin arbitration and issues the winning op.
//   Waits the op's fixed latency, captures the result and returns it on a response channel with a requester ID.
//   Sits between the instruction front-ends and the SixteenBit_ALU instance; the ALU itself is not modified.
// PARAMETERS
//   W        16  operand/result width
//   LAT_LOG  1   cycles from alu_start to valid alu_result for ADD/SUB/AND/OR/XOR/NOT
//   LAT_MUL  4   same, MUL (low W bits of product returned)
//   LAT_DIV  16  same, DIV (quotient returned); all LAT_* >= 1
// PORTS
//   clk         in   1  single clock, rising edge
//   reset       in   1  synchronous, active-high
//   req0_valid  in   1  requester 0 has an op
//   req0_ready  out  1  requester 0 op accepted this cycle when valid&ready
//   req0_op     in   3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 NOT
//   req0_a      in   W  operand a
//   req0_b      in   W  operand b (ignored for NOT)
//   req1_*      -    -  identical set for requester 1
//   alu_start   out  1  one-cycle pulse: alu_sel/alu_a/alu_b valid
//   alu_sel     out  3  opcode to ALU (held stable from start until capture)
//   alu_a       out  W  operand to ALU (held)
//   alu_b       out  W  operand to ALU (held)
//   alu_result  in   W  ALU output, sampled LAT_* cycles after alu_start
//   rsp_valid   out  1  response available
//   rsp_ready   in   1  consumer accepts response when valid&ready
//   rsp_id      out  1  requester that issued the op
//   rsp_data    out  W  result
//   rsp_err     out  1  op failed (divide by zero, see CONFIGURATION)
// BEHAVIOUR
//   Reset: state IDLE, rr pointer = 0 (req0 favoured first), all outputs 0 (ready, start, sel, a, b, rsp_*).
//   FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one op in flight at a time.
//   IDLE: req*_ready asserted combinationally only to arbitration winner; others 0. Winner = req with valid;
//     both valid -> the one the rr pointer favours; pointer then moves to the other requester.
//     On accept: latch op/a/b/id; go ISSUE. No valid -> stay IDLE.
//   ISSUE (1 cycle): alu_start=1; load counter with LAT of latched op; go WAIT.
//   WAIT: counter decrements each cycle; at counter==1 sample alu_result into rsp_data, rsp_err=0; go RESP.
//     Accept-to-rsp_valid latency = LAT+2 cycles (LAT_LOG default: accept T, start T+1, rsp_valid T+3).
//   RESP: rsp_valid=1, rsp_id/data/err stable until rsp_ready; on handshake go IDLE (new accept earliest next cycle).
//   req*_ready is 0 in ISSUE/WAIT/RESP; requesters hold valid and payload until accepted.
//   Single requester repeatedly valid is served back-to-back; rr pointer only favours the other when both valid.
//   reset mid-operation: abort in-flight op, no response emitted, return to reset values next cycle.
//   Arithmetic wraps mod 2^W (ALU behaviour); controller never alters alu_result.
// CONFIGURATION
//   ALU_DIV_ZERO_CHECK_EN defined: DIV with b==0 is accepted, never issued (no alu_start);
//     IDLE -> RESP directly next cycle with rsp_data=16'hFFFF, rsp_err=1.
//   Not defined: DIV by 0 issued normally, LAT_DIV waited, rsp_err always 0.
// STRUCTURE
//   Package alu_ctrl_pkg: opcode localparams (OP_ADD..OP_NOT), state encoding (ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP),
//     function op_latency(op) returning LAT_* value.
//   Sub-module rr_arbiter_2: inputs req[1:0], advance; outputs grant[1:0], one-hot or zero; owns rr pointer.
//   Counter width = $clog2(LAT_DIV+1).
// TESTING
//   1 req0 ADD a=3080 b=756, rsp_ready=1 -> alu_start at T+1, rsp_valid at T+3, rsp_id=0, data=3836, err=0.
//   2 req0 and req1 valid same cycle after reset -> req0 served first, then req1; repeat -> req1 served first.
//   3 req1 DIV a=100 b=7 -> alu_start then rsp_valid exactly LAT_DIV+1 cycles after start, data=14.
//   4 DIV a=5 b=0: with ALU_DIV_ZERO_CHECK_EN -> no alu_start, rsp data=16'hFFFF err=1 one cycle after accept;
//     without -> alu_start issued, err=0.
//   5 rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, both req*_ready=0, on release one handshake then IDLE.
//   6 reset asserted during WAIT of a MUL -> next cycle all outputs 0, no rsp_valid for aborted op; fresh op completes.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, controller state encoding and per-op latency
// lookup shared by the ALU arbitration controller and its arbiter.
package alu_ctrl_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam int LAT_LOG_DEF = 1;
   localparam int LAT_MUL_DEF = 4;
   localparam int LAT_DIV_DEF = 16;

   // Cycles from alu_start until alu_result is valid for this op.
   function automatic int op_latency(
      input logic [2:0] op,
      input int         lat_log,
      input int         lat_mul,
      input int         lat_div
   );
      int lat;
      lat = lat_log;
      unique case (1'b1)
         (op == OP_MUL): lat = lat_mul;
         (op == OP_DIV): lat = lat_div;
         default:        lat = lat_log;
      endcase
      return lat;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/alu_arbiter_ctrl_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter; the pointer only moves
// when both requesters contend, toward the one that just lost.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr;

   // Grant the lone requester, or the favoured one on contention.
   always_comb begin
      grant = 2'b00;
      unique case (1'b1)
         (req == 2'b11): grant = ptr ? 2'b10 : 2'b01;
         (req == 2'b01): grant = 2'b01;
         (req == 2'b10): grant = 2'b10;
         default:        grant = 2'b00;
      endcase
   end

   // Hand priority to the loser after a contended grant is taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= 1'b0;
      end else if (advance && req == 2'b11) begin
         ptr <= grant[0];
      end
   end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: shares one ALU between two requesters, one op in flight.
// Optional ALU_DIV_ZERO_CHECK_EN: DIV by zero answered at once with err=1.
module alu_arbiter_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int W       = 16,
   parameter int LAT_LOG = LAT_LOG_DEF,
   parameter int LAT_MUL = LAT_MUL_DEF,
   parameter int LAT_DIV = LAT_DIV_DEF
) (
   input  logic         clk,
   input  logic         reset,

   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [2:0]   req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,

   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [2:0]   req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,

   output logic         alu_start,
   output logic [2:0]   alu_sel,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_result,

   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   output logic         rsp_err
);

   localparam int LAT_MAX = max3(LAT_LOG, LAT_MUL, LAT_DIV);
   localparam int CW      = $clog2(LAT_MAX + 1);

   logic [1:0]   state;
   logic [CW-1:0] cnt;

   logic         idle;
   logic [1:0]   req;
   logic [1:0]   grant;
   logic         accept;
   logic         win_id;
   logic [2:0]   win_op;
   logic [W-1:0] win_a;
   logic [W-1:0] win_b;
   logic         win_dz;

   assign idle   = (state == ST_IDLE);
   assign req    = {req1_valid, req0_valid};
   assign accept = idle && (req != 2'b00);

   rr_arbiter_2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .advance (accept),
      .grant   (grant)
   );

   assign req0_ready = idle && grant[0];
   assign req1_ready = idle && grant[1];

   assign win_id = grant[1];
   assign win_op = grant[1] ? req1_op : req0_op;
   assign win_a  = grant[1] ? req1_a  : req0_a;
   assign win_b  = grant[1] ? req1_b  : req0_b;

`ifdef ALU_DIV_ZERO_CHECK_EN
   assign win_dz = (win_op == OP_DIV) && (win_b == '0);
`else
   assign win_dz = 1'b0;
`endif

   assign alu_start = (state == ST_ISSUE);
   assign rsp_valid = (state == ST_RESP);

   // Sequence one op: accept, issue, wait out latency, hold response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         alu_sel  <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         rsp_id   <= 1'b0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  alu_sel <= win_op;
                  alu_a   <= win_a;
                  alu_b   <= win_b;
                  rsp_id  <= win_id;
                  if (win_dz) begin
                     rsp_data <= '1;
                     rsp_err  <= 1'b1;
                     state    <= ST_RESP;
                  end else begin
                     state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               cnt   <= CW'(op_latency(alu_sel, LAT_LOG,
                                       LAT_MUL, LAT_DIV));
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  rsp_data <= alu_result;
                  rsp_err  <= 1'b0;
                  state    <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// tb_alu_arbiter_ctrl: vector table, corner sequences and a randomized
// run against a transaction-level model with a latency-exact ALU stand-in.
module tb_alu_arbiter_ctrl;

   localparam int NONE = 99;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_op = '0, req1_op = '0;
   logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        alu_start;
   logic [2:0]  alu_sel;
   logic [15:0] alu_a, alu_b, alu_result;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err;
   logic [15:0] rsp_data;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int k = 1000;

   alu_arbiter_ctrl dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .alu_start(alu_start), .alu_sel(alu_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] gold(input logic [2:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
      logic [31:0] p;
      p = 32'(a) * 32'(b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return p[15:0];
         3'd3: return (b == 0) ? 16'hFFFF : a / b;
         3'd4: return a & b;
         3'd5: return a | b;
         3'd6: return a ^ b;
         default: return ~a;
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] op);
      if (op == 3'd2) return 4;
      if (op == 3'd3) return 16;
      return 1;
   endfunction

   // ALU stand-in: correct result only exactly LAT cycles after start.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (alu_start) k <= 1;
      else if (k < 1000) k <= k + 1;
   end

   always_comb begin
      alu_result = gold(alu_sel, alu_a, alu_b);
      if (k != lat_of(alu_sel)) alu_result = alu_result ^ 16'h5A5A;
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_op(input int id, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        output int st_d, output int rs_d,
                        output logic r_id, output logic [15:0] r_data,
                        output logic r_err);
      int t_acc;
      bit got;
      st_d = NONE; rs_d = NONE; r_id = 0; r_data = 0; r_err = 0;
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      if (id == 0) begin
         req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
      end
      got = 0; t_acc = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
            got = 1; t_acc = cyc;
         end
      end
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      if (!got) check("accept_timeout", 0, 1);
      else begin
         for (int i = 0; i < 60 && rs_d == NONE; i++) begin
            @(negedge clk);
            if (alu_start && st_d == NONE) st_d = cyc - t_acc;
            if (rsp_valid) begin
               rs_d = cyc - t_acc;
               r_id = rsp_id; r_data = rsp_data; r_err = rsp_err;
            end
         end
      end
   endtask

   task automatic run_both(output int first);
      bit d0, d1;
      @(posedge clk); #1;
      rsp_ready = 1;
      req0_valid = 1; req0_op = 3'd0; req0_a = 1; req0_b = 2;
      req1_valid = 1; req1_op = 3'd1; req1_a = 9; req1_b = 4;
      first = NONE; d0 = 0; d1 = 0;
      for (int i = 0; i < 200 && !(d0 && d1); i++) begin
         @(negedge clk);
         if (req0_ready) begin if (first == NONE) first = 0; d0 = 1; end
         if (req1_ready) begin if (first == NONE) first = 1; d1 = 1; end
         @(posedge clk); #1;
         if (d0) req0_valid = 0;
         if (d1) req1_valid = 0;
      end
      req0_valid = 0; req1_valid = 0;
      repeat (10) @(posedge clk);
   endtask

   typedef struct {
      int          id;
      logic [2:0]  op;
      logic [15:0] a, b, d;
      logic        e;
      int          st, rs;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int st_d, rs_d, first, w, e_due;
      logic r_id, r_err, e_id, e_err, dz;
      logic [15:0] r_data, e_data;
      logic [2:0] e_op;
      logic [15:0] ea, eb;
      bit busy, busy_now, seen, late, drop0, drop1;
      int ptr_m;

      #200000000;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int st_d, rs_d, first, w, e_due;
      logic r_id, r_err, e_id, e_err, dz;
      logic [15:0] r_data, e_data, ea, eb;
      logic [2:0] e_op;
      bit busy, busy_now, seen, late, drop0, drop1, saw;
      int ptr_m;

      tbl[0] = '{0, 3'd0, 16'd3080, 16'd756, 16'd3836, 0, 1, 3};
      tbl[1] = '{0, 3'd1, 16'd5, 16'd7, 16'hFFFE, 0, 1, 3};
      tbl[2] = '{1, 3'd2, 16'd300, 16'd300, 16'h5F90, 0, 1, 6};
      tbl[3] = '{1, 3'd3, 16'd100, 16'd7, 16'd14, 0, 1, 18};
      tbl[4] = '{0, 3'd4, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 1, 3};
      tbl[5] = '{1, 3'd5, 16'hF000, 16'h000F, 16'hF00F, 0, 1, 3};
      tbl[6] = '{0, 3'd6, 16'hFFFF, 16'h1234, 16'hEDCB, 0, 1, 3};
      tbl[7] = '{1, 3'd7, 16'h1234, 16'hBEEF, 16'hEDCB, 0, 1, 3};
      tbl[8] = '{0, 3'd0, 16'hFFFF, 16'd1, 16'd0, 0, 1, 3};
`ifdef ALU_DIV_ZERO_CHECK_EN
      tbl[9] = '{0, 3'd3, 16'd5, 16'd0, 16'hFFFF, 1, NONE, 1};
`else
      tbl[9] = '{0, 3'd3, 16'd5, 16'd0, 16'hFFFF, 0, 1, 18};
`endif

      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      check("reset_outputs",
            {req0_ready, req1_ready, alu_start, alu_sel, alu_a, alu_b,
             rsp_valid, rsp_id, rsp_err}, 0);
      check("reset_rsp_data", rsp_data, 0);

      foreach (tbl[i]) begin
         do_op(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b,
               st_d, rs_d, r_id, r_data, r_err);
         check($sformatf("v%0d_start_lat", i), st_d, tbl[i].st);
         check($sformatf("v%0d_rsp_lat", i), rs_d, tbl[i].rs);
         check($sformatf("v%0d_id", i), r_id, tbl[i].id);
         check($sformatf("v%0d_data", i), r_data, tbl[i].d);
         check($sformatf("v%0d_err", i), r_err, tbl[i].e);
      end

      run_both(first);
      check("rr_first_round", first, 0);
      run_both(first);
      check("rr_second_round", first, 1);

      // response back-pressure with the other requester waiting
      @(posedge clk); #1;
      rsp_ready = 0;
      req0_valid = 1; req0_op = 3'd0; req0_a = 10; req0_b = 20;
      saw = 0;
      for (int i = 0; i < 20 && !saw; i++) begin
         @(negedge clk);
         saw = req0_ready;
      end
      @(posedge clk); #1;
      req0_valid = 0;
      req1_valid = 1; req1_op = 3'd6; req1_a = 16'h00FF; req1_b = 16'h0F0F;
      saw = 0;
      for (int i = 0; i < 20 && !saw; i++) begin
         @(negedge clk);
         saw = rsp_valid;
      end
      check("bp_rsp_arrives", saw, 1);
      for (int i = 0; i < 10; i++) begin
         check("bp_hold", {rsp_valid, rsp_id, rsp_err, rsp_data,
                           req0_ready, req1_ready},
               {1'b1, 1'b0, 1'b0, 16'd30, 1'b0, 1'b0});
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1;
      @(negedge clk);
      check("bp_release_valid", rsp_valid, 1);
      @(negedge clk);
      check("bp_after_hs", {rsp_valid, req1_ready}, 2'b01);
      @(posedge clk); #1;
      req1_valid = 0;
      saw = 0;
      for (int i = 0; i < 20 && !saw; i++) begin
         @(negedge clk);
         saw = rsp_valid;
      end
      check("bp_next_rsp", {saw, rsp_id, rsp_data}, {1'b1, 1'b1, 16'h0FF0});
      @(posedge clk);

      // reset in the middle of a MUL
      @(posedge clk); #1;
      req0_valid = 1; req0_op = 3'd2; req0_a = 16'd300; req0_b = 16'd300;
      saw = 0;
      for (int i = 0; i < 20 && !saw; i++) begin
         @(negedge clk);
         saw = req0_ready;
      end
      @(posedge clk); #1;
      req0_valid = 0;
      saw = 0;
      for (int i = 0; i < 20 && !saw; i++) begin
         @(negedge clk);
         saw = alu_start;
      end
      check("mr_started", saw, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      check("mr_outputs_zero",
            {req0_ready, req1_ready, alu_start, alu_sel, alu_a, alu_b,
             rsp_valid, rsp_id, rsp_err}, 0);
      check("mr_rsp_data_zero", rsp_data, 0);
      saw = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) saw = 1;
      end
      check("mr_no_rsp", saw, 0);
      do_op(0, 3'd2, 16'd300, 16'd300, st_d, rs_d, r_id, r_data, r_err);
      check("mr_fresh", {rs_d[7:0], r_id, r_data, r_err},
            {8'd6, 1'b0, 16'h5F90, 1'b0});

      // randomized traffic against a transaction-level model
      @(posedge clk); #1;
      reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      busy = 0; ptr_m = 0; drop0 = 0; drop1 = 0; seen = 0; late = 0;
      e_id = 0; e_err = 0; e_data = 0; e_due = 0;
      for (int c = 0; c < 500; c++) begin
         @(posedge clk); #1;
         if (drop0) req0_valid = 0;
         if (drop1) req1_valid = 0;
         drop0 = 0; drop1 = 0;
         if (!req0_valid && $urandom_range(0, 2) == 0) begin
            req0_valid = 1;
            req0_op = 3'($urandom_range(0, 7));
            req0_a = 16'($urandom);
            req0_b = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
         end
         if (!req1_valid && $urandom_range(0, 2) == 0) begin
            req1_valid = 1;
            req1_op = 3'($urandom_range(0, 7));
            req1_a = 16'($urandom);
            req1_b = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         busy_now = busy;
         if (busy_now) begin
            if (rsp_valid) begin
               if (!seen) check("rnd_rsp_lat", cyc, e_due);
               seen = 1;
               check("rnd_rsp", {rsp_id, rsp_err, rsp_data},
                     {e_id, e_err, e_data});
               if (rsp_ready) busy = 0;
            end else if (cyc > e_due && !late) begin
               late = 1;
               check("rnd_rsp_late", cyc, e_due);
            end
            check("rnd_ready_busy", {req1_ready, req0_ready}, 0);
         end else begin
            check("rnd_no_rsp", rsp_valid, 0);
            if (req0_valid || req1_valid) begin
               if (req0_valid && req1_valid) w = ptr_m;
               else w = req0_valid ? 0 : 1;
               check("rnd_grant", {req1_ready, req0_ready},
                     (w == 1) ? 2'b10 : 2'b01);
               if (req0_valid && req1_valid) ptr_m = 1 - w;
               e_op = (w == 1) ? req1_op : req0_op;
               ea = (w == 1) ? req1_a : req0_a;
               eb = (w == 1) ? req1_b : req0_b;
               e_id = (w == 1);
               e_data = gold(e_op, ea, eb);
               e_err = 0;
               e_due = cyc + lat_of(e_op) + 2;
               dz = (e_op == 3'd3) && (eb == 0);
`ifdef ALU_DIV_ZERO_CHECK_EN
               if (dz) begin
                  e_data = 16'hFFFF; e_err = 1; e_due = cyc + 1;
               end
`else
               if (dz) e_err = 0;
`endif
               busy = 1; seen = 0; late = 0;
               if (w == 1) drop1 = 1; else drop0 = 1;
            end else begin
               check("rnd_ready_idle", {req1_ready, req0_ready}, 0);
            end
         end
      end
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0; rsp_ready = 1;
      repeat (30) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
